// File: rtl/line_plotter_pkg.sv
// Shared definitions for the line plotter and other draw engines on the
// 160x120, 3-bit-colour frame buffer: coordinate widths, screen limits,
// colour constants, engine state encoding and an on-screen test.
package line_plotter_pkg;

    localparam int XW    = 8;
    localparam int YW    = 7;
    localparam int CW    = 3;
    localparam int EW    = XW + 2;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;

    localparam logic [CW-1:0] BLACK   = 3'b000;
    localparam logic [CW-1:0] BLUE    = 3'b001;
    localparam logic [CW-1:0] GREEN   = 3'b010;
    localparam logic [CW-1:0] CYAN    = 3'b011;
    localparam logic [CW-1:0] RED     = 3'b100;
    localparam logic [CW-1:0] MAGENTA = 3'b101;
    localparam logic [CW-1:0] YELLOW  = 3'b110;
    localparam logic [CW-1:0] WHITE   = 3'b111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAW  = 3'd1,
        PROBE = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } state_t;

    function automatic logic on_screen(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return (int'(px) <= X_MAX) && (int'(py) <= Y_MAX);
    endfunction

endpackage

// File: rtl/line_plotter_if.sv
// Command, status and frame-buffer port bundle of the line plotter.
// The master side is the processor plus the frame buffer read data; the
// slave side is the draw engine.
interface line_plotter_if;
    import line_plotter_pkg::*;

    logic          start;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
    logic [CW-1:0] color;
    logic [CW-1:0] image_color;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] plot_color;
    logic          plot;
    logic          busy;
    logic          done;
    logic          hit;

    modport master (
        output start, x0, y0, x1, y1, color, image_color,
        input  x, y, plot_color, plot, busy, done, hit
    );

    modport slave (
        input  start, x0, y0, x1, y1, color, image_color,
        output x, y, plot_color, plot, busy, done, hit
    );

endinterface

// File: rtl/line_plotter_line_step.sv
// One combinational Bresenham step: given the current point and error term,
// produce the next point and error. x and y may both move (diagonal step).
module line_step
    import line_plotter_pkg::*;
(
    input  logic signed [EW-1:0] err,
    input  logic signed [EW-1:0] dx,
    input  logic signed [EW-1:0] dy,
    input  logic                 sx_neg,
    input  logic                 sy_neg,
    input  logic [XW-1:0]        x,
    input  logic [YW-1:0]        y,
    output logic [XW-1:0]        x_next,
    output logic [YW-1:0]        y_next,
    output logic signed [EW-1:0] err_next
);

    logic signed [EW-1:0] e2;

    // Both comparisons use the error from before this step.
    always_comb begin
        e2       = err <<< 1;
        x_next   = x;
        y_next   = y;
        err_next = err;
        if (e2 >= dy) begin
            err_next = err_next + dy;
            x_next   = sx_neg ? x - XW'(1) : x + XW'(1);
        end
        if (e2 <= dx) begin
            err_next = err_next + dx;
            y_next   = sy_neg ? y - YW'(1) : y + YW'(1);
        end
    end

endmodule

// File: rtl/line_plotter.sv
// Bresenham line-drawing engine driving the frame-buffer write port.
// Define LINE_PLOTTER_COLLISION_EN to probe each pixel first and stop on
// the first non-black pixel already in the frame buffer.
module line_plotter
    import line_plotter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    line_plotter_if.slave bus
);

    state_t               state_q, state_d;
    logic [XW-1:0]        x_q, x_d, x1_q, x1_d;
    logic [YW-1:0]        y_q, y_d, y1_q, y1_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic [CW-1:0]        plot_color_q, plot_color_d;
    logic                 plot_q, plot_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef LINE_PLOTTER_COLLISION_EN
    logic                 hit_q, hit_d;
`endif

    logic [XW-1:0]        x_span, x_next;
    logic [YW-1:0]        y_span, y_next;
    logic signed [EW-1:0] dx_start, dy_start, err_start, err_next;
    logic                 at_end;

    line_step u_step (
        .err      (err_q),
        .dx       (dx_q),
        .dy       (dy_q),
        .sx_neg   (sx_neg_q),
        .sy_neg   (sy_neg_q),
        .x        (x_q),
        .y        (y_q),
        .x_next   (x_next),
        .y_next   (y_next),
        .err_next (err_next)
    );

    assign at_end = (x_q == x1_q) && (y_q == y1_q);

    // Initial deltas and error term from the command inputs, used on accept.
    always_comb begin
        x_span    = (bus.x0 < bus.x1) ? bus.x1 - bus.x0 : bus.x0 - bus.x1;
        y_span    = (bus.y0 < bus.y1) ? bus.y1 - bus.y0 : bus.y0 - bus.y1;
        dx_start  = $signed(EW'(x_span));
        dy_start  = -$signed(EW'(y_span));
        err_start = dx_start + dy_start;
    end

    // Next-state and next-output logic; outputs are registered one pixel ahead.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        x1_d         = x1_q;
        y1_d         = y1_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        err_d        = err_q;
        sx_neg_d     = sx_neg_q;
        sy_neg_d     = sy_neg_q;
        plot_color_d = plot_color_q;
        plot_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef LINE_PLOTTER_COLLISION_EN
        hit_d        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d          = bus.x0;
                    y_d          = bus.y0;
                    x1_d         = bus.x1;
                    y1_d         = bus.y1;
                    dx_d         = dx_start;
                    dy_d         = dy_start;
                    err_d        = err_start;
                    sx_neg_d     = !(bus.x0 < bus.x1);
                    sy_neg_d     = !(bus.y0 < bus.y1);
                    plot_color_d = bus.color;
                    busy_d       = 1'b1;
`ifdef LINE_PLOTTER_COLLISION_EN
                    state_d      = PROBE;
`else
                    state_d      = DRAW;
                    plot_d       = on_screen(bus.x0, bus.y0);
`endif
                end
            end
            DRAW: begin
                if (at_end) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    x_d    = x_next;
                    y_d    = y_next;
                    err_d  = err_next;
                    plot_d = on_screen(x_next, y_next);
                end
            end
`ifdef LINE_PLOTTER_COLLISION_EN
            PROBE: begin
                state_d = CHECK;
                plot_d  = on_screen(x_q, y_q);
            end
            CHECK: begin
                if (bus.image_color != BLACK) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    hit_d   = 1'b1;
                end else if (at_end) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = PROBE;
                    x_d     = x_next;
                    y_d     = y_next;
                    err_d   = err_next;
                end
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            x1_q         <= '0;
            y1_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            err_q        <= '0;
            sx_neg_q     <= 1'b0;
            sy_neg_q     <= 1'b0;
            plot_color_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef LINE_PLOTTER_COLLISION_EN
            hit_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            x1_q         <= x1_d;
            y1_q         <= y1_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            err_q        <= err_d;
            sx_neg_q     <= sx_neg_d;
            sy_neg_q     <= sy_neg_d;
            plot_color_q <= plot_color_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef LINE_PLOTTER_COLLISION_EN
            hit_q        <= hit_d;
`endif
        end
    end

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.plot_color = plot_color_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef LINE_PLOTTER_COLLISION_EN
    // The write is suppressed in the same cycle the read data shows an obstacle.
    assign bus.plot       = plot_q && (bus.image_color == BLACK);
    assign bus.hit        = hit_q;
`else
    assign bus.plot       = plot_q;
    assign bus.hit        = 1'b0;
`endif

endmodule

// File: tb/tb_line_plotter.sv
// Directed self-checking bench for line_plotter. Cycle 0 is the cycle in
// which start is driven; outputs are sampled 1 time unit after each edge.
// Build with LINE_PLOTTER_COLLISION_EN defined to exercise the collision mode.
module tb_line_plotter;
    import line_plotter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic          obst_en;
    logic [XW-1:0] obst_x;
    logic [YW-1:0] obst_y;
    logic [CW-1:0] obst_color;

`ifndef LINE_PLOTTER_COLLISION_EN
    int steep_x [11] = '{10, 10, 9, 9, 9, 8, 8, 8, 8, 7, 7};
`endif

    line_plotter_if bus ();

    line_plotter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Frame buffer read port: black everywhere except one optional obstacle,
    // data appears one cycle after the address.
    always @(posedge clk)
        bus.image_color <= (obst_en && bus.x == obst_x && bus.y == obst_y) ? obst_color : BLACK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1, input int acol);
        bus.x0    = XW'(ax0);
        bus.y0    = YW'(ay0);
        bus.x1    = XW'(ax1);
        bus.y1    = YW'(ay1);
        bus.color = CW'(acol);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic checkPixel(input string tag, input int ex, input int ey, input int eplot, input int ecol);
        checkOutput({tag, " x"}, 32'(bus.x), ex);
        checkOutput({tag, " y"}, 32'(bus.y), ey);
        checkOutput({tag, " plot"}, 32'(bus.plot), eplot);
        checkOutput({tag, " plot_color"}, 32'(bus.plot_color), ecol);
        checkOutput({tag, " busy"}, 32'(bus.busy), 1);
        checkOutput({tag, " done"}, 32'(bus.done), 0);
    endtask

    task automatic checkDone(input string tag, input int ehit);
        checkOutput({tag, " done"}, 32'(bus.done), 1);
        checkOutput({tag, " busy@done"}, 32'(bus.busy), 0);
        checkOutput({tag, " plot@done"}, 32'(bus.plot), 0);
        checkOutput({tag, " hit"}, 32'(bus.hit), ehit);
        tick();
        checkOutput({tag, " done cleared"}, 32'(bus.done), 0);
        checkOutput({tag, " busy idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.x0     = '0;
        bus.y0     = '0;
        bus.x1     = '0;
        bus.y1     = '0;
        bus.color  = '0;
        obst_en    = 1'b0;
        obst_x     = '0;
        obst_y     = '0;
        obst_color = BLACK;
        tick();
        tick();
        checkOutput("reset x", 32'(bus.x), 0);
        checkOutput("reset y", 32'(bus.y), 0);
        checkOutput("reset plot_color", 32'(bus.plot_color), 0);
        checkOutput("reset plot", 32'(bus.plot), 0);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset done", 32'(bus.done), 0);
        checkOutput("reset hit", 32'(bus.hit), 0);
        reset = 1'b0;
        tick();
        checkOutput("idle plot", 32'(bus.plot), 0);
        checkOutput("idle busy", 32'(bus.busy), 0);

`ifndef LINE_PLOTTER_COLLISION_EN
        $display("[TB] horizontal (0,0)->(5,0)");
        applyStimulus(0, 0, 5, 0, 3);
        for (int i = 0; i < 6; i++) begin
            checkPixel($sformatf("horiz[%0d]", i), i, 0, 1, 3);
            tick();
        end
        checkDone("horiz", 0);

        $display("[TB] steep negative (10,20)->(7,10)");
        applyStimulus(10, 20, 7, 10, 6);
        for (int i = 0; i < 11; i++) begin
            checkPixel($sformatf("steep[%0d]", i), steep_x[i], 20 - i, 1, 6);
            tick();
        end
        checkDone("steep", 0);

        $display("[TB] diagonal (0,0)->(3,3)");
        applyStimulus(0, 0, 3, 3, 2);
        for (int i = 0; i < 4; i++) begin
            checkPixel($sformatf("diag[%0d]", i), i, i, 1, 2);
            tick();
        end
        checkDone("diag", 0);

        $display("[TB] single point (4,4)");
        applyStimulus(4, 4, 4, 4, 7);
        checkPixel("point", 4, 4, 1, 7);
        tick();
        checkDone("point", 0);

        $display("[TB] start while busy is ignored");
        applyStimulus(10, 5, 15, 5, 5);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                bus.x0    = 8'd100;
                bus.y0    = 7'd100;
                bus.x1    = 8'd0;
                bus.y1    = 7'd0;
                bus.color = 3'd1;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            checkPixel($sformatf("ignore[%0d]", i), 10 + i, 5, 1, 5);
            tick();
        end
        bus.start = 1'b0;
        checkDone("ignore", 0);

        $display("[TB] off-screen x (157,118)->(162,118)");
        applyStimulus(157, 118, 162, 118, 1);
        for (int i = 0; i < 6; i++) begin
            checkPixel($sformatf("offx[%0d]", i), 157 + i, 118, (i < 3) ? 1 : 0, 1);
            tick();
        end
        checkDone("offx", 0);

        $display("[TB] off-screen y (0,118)->(0,121)");
        applyStimulus(0, 118, 0, 121, 4);
        for (int i = 0; i < 4; i++) begin
            checkPixel($sformatf("offy[%0d]", i), 0, 118 + i, (i < 2) ? 1 : 0, 4);
            tick();
        end
        checkDone("offy", 0);

        $display("[TB] reset mid-line");
        applyStimulus(0, 0, 5, 0, 3);
        checkPixel("abort[0]", 0, 0, 1, 3);
        tick();
        checkPixel("abort[1]", 1, 0, 1, 3);
        tick();
        checkPixel("abort[2]", 2, 0, 1, 3);
        reset = 1'b1;
        tick();
        checkOutput("abort plot", 32'(bus.plot), 0);
        checkOutput("abort busy", 32'(bus.busy), 0);
        checkOutput("abort done", 32'(bus.done), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("abort quiet plot[%0d]", i), 32'(bus.plot), 0);
            checkOutput($sformatf("abort quiet done[%0d]", i), 32'(bus.done), 0);
        end

        $display("[TB] shallow (20,30)->(22,31) after abort");
        applyStimulus(20, 30, 22, 31, 2);
        checkPixel("shallow[0]", 20, 30, 1, 2);
        tick();
        checkPixel("shallow[1]", 21, 31, 1, 2);
        tick();
        checkPixel("shallow[2]", 22, 31, 1, 2);
        tick();
        checkDone("shallow", 0);
`else
        $display("[TB] collision at (2,0) on (0,0)->(5,0)");
        obst_en    = 1'b1;
        obst_x     = 8'd2;
        obst_y     = 7'd0;
        obst_color = 3'd4;
        applyStimulus(0, 0, 5, 0, 3);
        for (int i = 0; i < 2; i++) begin
            checkPixel($sformatf("coll probe[%0d]", i), i, 0, 0, 3);
            tick();
            checkPixel($sformatf("coll check[%0d]", i), i, 0, 1, 3);
            tick();
        end
        checkPixel("coll probe[2]", 2, 0, 0, 3);
        tick();
        checkPixel("coll check[2]", 2, 0, 0, 3);
        tick();
        checkDone("coll", 1);

        $display("[TB] no obstacle (0,0)->(5,0)");
        obst_en = 1'b0;
        applyStimulus(0, 0, 5, 0, 3);
        for (int i = 0; i < 6; i++) begin
            checkPixel($sformatf("clear probe[%0d]", i), i, 0, 0, 3);
            tick();
            checkPixel($sformatf("clear check[%0d]", i), i, 0, 1, 3);
            tick();
        end
        checkDone("clear", 0);

        $display("[TB] obstacle on first pixel (0,0)->(3,3)");
        obst_en    = 1'b1;
        obst_x     = 8'd0;
        obst_y     = 7'd0;
        obst_color = 3'd1;
        applyStimulus(0, 0, 3, 3, 6);
        checkPixel("first probe", 0, 0, 0, 6);
        tick();
        checkPixel("first check", 0, 0, 0, 6);
        tick();
        checkDone("first", 1);

        $display("[TB] single point (4,4) with no obstacle");
        obst_en = 1'b0;
        applyStimulus(4, 4, 4, 4, 7);
        checkPixel("point probe", 4, 4, 0, 7);
        tick();
        checkPixel("point check", 4, 4, 1, 7);
        tick();
        checkDone("point", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_plotter.md
Name: line_plotter

Overview:
- Hardware line-drawing engine feeding the processor-side write port of the 160x120, 3-bit-colour frame buffer (image RAM).
- Accepts endpoint pairs and a colour, then walks the line with integer Bresenham, emitting one pixel write per step on x/y/plot_color/plot.
- Sits beside or under the processor, which issues draw commands.
- Also reads back the frame-buffer pixel (image_color) for optional collision stopping.

Parameters:
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.
- X_MAX, 159, largest on-screen x.
- Y_MAX, 119, largest on-screen y.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- x0  in  XW  start x.
- y0  in  YW  start y.
- x1  in  XW  end x.
- y1  in  YW  end y.
- color  in  3  line colour.
- image_color  in  3  frame-buffer read data at (x,y); 1-cycle read latency.
- x  out  XW  pixel address.
- y  out  YW  pixel address.
- plot_color  out  3  write data.
- plot  out  1  write enable.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at completion.
- hit  out  1  valid with done; 1 if stopped by collision.

Behaviour:
- Reset (sync, active-high): state=IDLE; x, y, plot_color, plot, busy, done, hit all 0. Reset mid-line aborts it on the next edge with no further plot and no done.
- IDLE, start=1: latch inputs. Compute the following, with signed arithmetic at XW+2 bits:
  - dx = |x1-x0|, dy = -|y1-y0|
  - sx = +1 if x0<x1 else -1; sy likewise from y0, y1
  - err = dx+dy
  - Then go to DRAW and set busy.
- IDLE, start=0: all outputs idle. start is ignored while busy; no queueing.
- DRAW (one pixel per cycle):
  - Drive x, y, plot_color=color latched at start, plot=1.
  - If (x,y)==(x1,y1), go to FIN. Otherwise e2=2*err:
    - if e2>=dy: err+=dy, x+=sx
    - if e2<=dx: err+=dx, y+=sy
  - Both updates may occur in the same cycle (diagonal step).
- FIN: done=1, busy=0, plot=0 for one cycle, then IDLE.
- Latency: start in cycle 0 → first plot in cycle 1. A line of N=max(|x1-x0|,|y1-y0|)+1 pixels plots in cycles 1..N; done in cycle N+1. A new start is accepted in cycle N+2.
- Single point (x0,y0)==(x1,y1): exactly one plot, then done.
- Off-screen pixels (x>X_MAX or y>Y_MAX): plot forced 0 for that step, stepping continues, and the cycle count is unchanged.
- x and y hold their last values when idle; plot is 0 except in DRAW.

Optional Feature:
- Macro: LINE_PLOTTER_COLLISION_EN.
- Enabled, each pixel takes 2 cycles:
  - PROBE: drive x, y with plot=0.
  - CHECK: sample image_color. If nonzero (not black), plot nothing and go to FIN with hit=1. Otherwise plot=1 at the same x/y and step as in DRAW.
  - The first pixel is checked too.
  - Completion latency without a hit is 2N+1 cycles.
- Disabled: image_color is unused, hit is tied 0, and timing is as in Behaviour.

Decomposition:
- Shared package: coordinate widths, screen limits (X_MAX/Y_MAX), colour constants (BLACK=3'b000 …), and the state encoding IDLE/DRAW/PROBE/CHECK/FIN, reusable by the processor and other draw engines.
- One natural sub-module: line_step, a purely combinational Bresenham step. Inputs: err, dx, dy, sx, sy, x, y. Outputs: next x, next y, next err. This keeps the FSM small and lets the step be unit-tested in isolation.

Test Plan:
- Horizontal (0,0)→(5,0), color=3'd3 → plots x=0..5, y=0 in cycles 1..6, plot_color=3; done at cycle 7; busy high for cycles 1..6.
- Steep negative (10,20)→(7,10) → exactly 11 plots; y decrements every cycle; x steps total −3; last plot (7,10).
- Diagonal (0,0)→(3,3) → plots (0,0),(1,1),(2,2),(3,3), one per cycle; single point (4,4)→(4,4) → one plot, then done.
- start pulsed again at cycle 3 of a 6-pixel line with different coordinates → ignored; the original line completes unchanged.
- Reset asserted in cycle 3 of a line → from the next edge plot=0, busy=0, no done pulse; a subsequent start draws normally.
- COLLISION_EN: frame buffer (2,0)=3'd4, line (0,0)→(5,0) → pixels (0,0),(1,0) plotted; no write to (2,0); done with hit=1 at cycle 7. No obstacle → 6 plots, hit=0, done at cycle 13.
